// File: rtl/wimax_pkg.sv
// Shared definitions for the WiMAX modulation blocks: QPSK constellation
// constants (Q1.15, +/-1/sqrt(2)), default interleaver block size, sample type
// and the QPSK bit-pair state encoding.
package wimax_pkg;

    localparam int          NCBPS_DEFAULT = 192;
    localparam logic [15:0] QPSK_POS      = 16'h5A82;
    localparam logic [15:0] QPSK_NEG      = 16'hA57E;

    typedef logic signed [15:0] iq_t;

    typedef enum logic {
        BIT0 = 1'b0,
        BIT1 = 1'b1
    } qpsk_state_t;

    // Gray-mapped QPSK axis value: bit 0 -> positive, bit 1 -> negative.
    function automatic iq_t qpsk_map(input logic b);
        return b ? iq_t'(QPSK_NEG) : iq_t'(QPSK_POS);
    endfunction

endpackage

// File: rtl/qpsk_skid_buffer.sv
// Two-entry output FIFO for the QPSK modulator. full is derived only from the
// occupancy register, so upstream ready carries no path from pop_ready.
module qpsk_skid_buffer #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         full,
    input  logic         pop_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem [0:1];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         pop;

    assign pop       = out_valid && pop_ready;
    assign out_valid = (count != 2'd0);
    assign full      = (count == 2'd2);
    assign out_data  = mem[rd_ptr];

    // Storage, pointers and occupancy; callers never push while full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/qpsk_modulator.sv
// QPSK mapper: pairs serial interleaved bits into I/Q symbols (first bit -> I,
// second -> Q) and tags the last symbol of each NCBPS-bit block.
// Build option: define QPSK_MOD_SKID_EN to place a 2-entry skid buffer on the
// output so ready_out no longer depends combinationally on ready_in.
//
//   state | meaning
//   ------+----------------------------------------
//   BIT0  | waiting for the first (I) bit of a pair
//   BIT1  | I bit held, waiting for the Q bit
module qpsk_modulator
    import wimax_pkg::*;
#(
    parameter int NCBPS = NCBPS_DEFAULT,
    parameter int IQ_W  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            data_in,
    input  logic            valid_in,
    output logic            ready_out,
    output logic [IQ_W-1:0] i_out,
    output logic [IQ_W-1:0] q_out,
    output logic            valid_out,
    input  logic            ready_in,
    output logic            last_out
);

    localparam int NSYM  = NCBPS / 2;
    localparam int CNT_W = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NSYM - 1);

    generate
        if ((NCBPS % 2) != 0 || NCBPS < 2) begin : g_bad_ncbps
            $error("qpsk_modulator: NCBPS must be a positive even number");
        end
    endgenerate

    // Re-express a Q1.15 constant in Q1.(IQ_W-1): left-align, keep IQ_W MSBs.
    function automatic logic [IQ_W-1:0] to_iq(input iq_t v);
        logic [IQ_W+15:0] ext;
        ext = {v, {IQ_W{1'b0}}};
        return ext[IQ_W+15 -: IQ_W];
    endfunction

    qpsk_state_t      state_q;
    qpsk_state_t      state_d;
    logic             held_q;
    logic [CNT_W-1:0] sym_cnt_q;
    logic             accept;
    logic             sym_load;
    logic [IQ_W-1:0]  sym_i;
    logic [IQ_W-1:0]  sym_q;
    logic             sym_last;

    assign accept   = valid_in && ready_out;
    assign sym_load = accept && (state_q == BIT1);
    assign sym_i    = to_iq(qpsk_map(held_q));
    assign sym_q    = to_iq(qpsk_map(data_in));
    assign sym_last = (sym_cnt_q == LAST_IDX);

    // Next state: every accepted bit toggles between the I and Q slot.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = (state_q == BIT0) ? BIT1 : BIT0;
        end
    end

    // State register and held I bit; a partial pair waits across valid gaps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BIT0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept && (state_q == BIT0)) begin
                held_q <= data_in;
            end
        end
    end

    // Symbol index within the block, advanced as each symbol leaves the mapper.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sym_cnt_q <= '0;
        end else if (sym_load) begin
            sym_cnt_q <= sym_last ? '0 : sym_cnt_q + 1'b1;
        end
    end

`ifdef QPSK_MOD_SKID_EN
    localparam int SW = 2 * IQ_W + 1;

    logic          skid_full;
    logic [SW-1:0] skid_data;

    qpsk_skid_buffer #(
        .W (SW)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (sym_load),
        .push_data ({sym_i, sym_q, sym_last}),
        .full      (skid_full),
        .pop_ready (ready_in),
        .out_valid (valid_out),
        .out_data  (skid_data)
    );

    assign {i_out, q_out, last_out} = skid_data;
    assign ready_out = !skid_full;
`else
    // In BIT1 the Q bit creates a symbol, so it may only be taken if the
    // output register is free or retiring this cycle.
    assign ready_out = (state_q == BIT0) || !valid_out || ready_in;

    // Single output register: load replaces a retiring symbol with no bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out <= 1'b0;
            i_out     <= '0;
            q_out     <= '0;
            last_out  <= 1'b0;
        end else if (sym_load) begin
            valid_out <= 1'b1;
            i_out     <= sym_i;
            q_out     <= sym_q;
            last_out  <= sym_last;
        end else if (valid_out && ready_in) begin
            valid_out <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_qpsk_modulator.sv
// Self-checking bench for qpsk_modulator (either build). Symbols seen on the
// output are collected and compared against a list computed from the bits sent.
module tb_qpsk_modulator;

    localparam int NCBPS = 192;
    localparam int NSYM  = NCBPS / 2;
    localparam logic [15:0] POS = 16'h5A82;
    localparam logic [15:0] NEG = 16'hA57E;

    typedef struct {
        logic [15:0] i;
        logic [15:0] q;
        logic        last;
        int          cyc;
    } sym_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        data_in = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic [15:0] i_out;
    logic [15:0] q_out;
    logic        valid_out;
    logic        ready_in = 1'b1;
    logic        last_out;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc_cyc = 0;
    sym_t obs[$];

    qpsk_modulator #(.NCBPS(NCBPS), .IQ_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .i_out     (i_out),
        .q_out     (q_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .last_out  (last_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every transfer; sampled mid-cycle, it completes at the next edge.
    always @(negedge clk) begin
        if (!reset && valid_out && ready_in) begin
            obs.push_back('{i: i_out, q: q_out, last: last_out, cyc: cyc});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Reference model: pairs of bits -> axis values, last tag from symbol position.
    function automatic void build_exp(input logic bits[$], input int base, output sym_t e[$]);
        e.delete();
        for (int k = 0; k < bits.size() / 2; k++) begin
            e.push_back('{i: bits[2*k] ? NEG : POS,
                          q: bits[2*k+1] ? NEG : POS,
                          last: ((base + k) % NSYM) == NSYM - 1,
                          cyc: 0});
        end
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        obs.delete();
    endtask

    task automatic send_bit(input logic b);
        int n;
        valid_in = 1'b1;
        data_in = b;
        n = 0;
        @(negedge clk);
        while (!ready_out && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!ready_out) begin
            checks++;
            errors++;
            $display("FAIL send_bit: ready_out got 0 for 200 cycles, expected 1");
        end
        @(posedge clk); #1;
        last_acc_cyc = cyc;
        valid_in = 1'b0;
    endtask

    task automatic wait_syms(input int n);
        int k;
        k = 0;
        while (obs.size() < n && k < 2000) begin
            @(posedge clk);
            k++;
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (valid_out !== 1'b0 || i_out !== 16'h0 || q_out !== 16'h0 || last_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b i=%h q=%h l=%b, expected v=0 i=0000 q=0000 l=0",
                     valid_out, i_out, q_out, last_out);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ready_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: ready_out got %b, expected 1", ready_out);
        end
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_valid: valid_out got %b, expected 0", valid_out);
        end
    endtask

    task automatic test_byte_4b();
        logic bits[$];
        logic [15:0] ei[4];
        logic [15:0] eq[4];
        int t;
        bits = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        ei = '{16'h5A82, 16'h5A82, 16'hA57E, 16'hA57E};
        eq = '{16'hA57E, 16'h5A82, 16'h5A82, 16'hA57E};
        do_reset();
        t = 0;
        foreach (bits[k]) begin
            send_bit(bits[k]);
            if (k == 1) t = last_acc_cyc;
        end
        wait_syms(4);
        checks++;
        if (obs.size() != 4) begin
            errors++;
            $display("FAIL byte_count: got %0d symbols, expected 4", obs.size());
        end else begin
            checks++;
            if (obs[0].cyc != t) begin
                errors++;
                $display("FAIL byte_latency: first symbol cycle got %0d, expected %0d", obs[0].cyc, t);
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (obs[k].i !== ei[k] || obs[k].q !== eq[k] || obs[k].last !== 1'b0) begin
                    errors++;
                    $display("FAIL byte_sym%0d: got (%h,%h,l=%b), expected (%h,%h,l=0)",
                             k, obs[k].i, obs[k].q, obs[k].last, ei[k], eq[k]);
                end
                if (k > 0) begin
                    checks++;
                    if (obs[k].cyc - obs[k-1].cyc != 2) begin
                        errors++;
                        $display("FAIL byte_spacing%0d: got %0d cycles, expected 2",
                                 k, obs[k].cyc - obs[k-1].cyc);
                    end
                end
            end
        end
    endtask

    task automatic test_full_blocks();
        logic bits[$];
        sym_t exp[$];
        do_reset();
        for (int k = 0; k < 2 * NCBPS; k++) bits.push_back(1'($urandom));
        build_exp(bits, 0, exp);
        foreach (bits[k]) send_bit(bits[k]);
        wait_syms(exp.size());
        checks++;
        if (obs.size() != exp.size()) begin
            errors++;
            $display("FAIL blocks_count: got %0d symbols, expected %0d", obs.size(), exp.size());
        end else begin
            for (int k = 0; k < exp.size(); k++) begin
                checks++;
                if (obs[k].i !== exp[k].i || obs[k].q !== exp[k].q || obs[k].last !== exp[k].last) begin
                    errors++;
                    $display("FAIL blocks_sym%0d: got (%h,%h,l=%b), expected (%h,%h,l=%b)",
                             k, obs[k].i, obs[k].q, obs[k].last, exp[k].i, exp[k].q, exp[k].last);
                end
                if (k > 0) begin
                    checks++;
                    if (obs[k].cyc - obs[k-1].cyc != 2) begin
                        errors++;
                        $display("FAIL blocks_spacing%0d: got %0d cycles, expected 2",
                                 k, obs[k].cyc - obs[k-1].cyc);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic bits[$];
        sym_t exp[$];
        do_reset();
        for (int k = 0; k < 40; k++) bits.push_back(1'($urandom));
        build_exp(bits, 0, exp);
        fork
            begin
                foreach (bits[k]) send_bit(bits[k]);
            end
            begin
                logic [15:0] hi;
                logic [15:0] hq;
                logic        hl;
                int          n;
                repeat (3) @(posedge clk);
                n = 0;
                @(posedge clk); #1;
                while (!valid_out && n < 50) begin
                    @(posedge clk); #1;
                    n++;
                end
                ready_in = 1'b0;
                hi = i_out;
                hq = q_out;
                hl = last_out;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    checks++;
                    if (valid_out !== 1'b1 || i_out !== hi || q_out !== hq || last_out !== hl) begin
                        errors++;
                        $display("FAIL stall_hold%0d: got v=%b (%h,%h,l=%b), expected v=1 (%h,%h,l=%b)",
                                 s, valid_out, i_out, q_out, last_out, hi, hq, hl);
                    end
                end
                checks++;
                if (ready_out !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_ready: ready_out got %b after 5 stalled cycles, expected 0", ready_out);
                end
                @(posedge clk); #1;
                ready_in = 1'b1;
            end
        join
        wait_syms(exp.size());
        checks++;
        if (obs.size() != exp.size()) begin
            errors++;
            $display("FAIL stall_count: got %0d symbols, expected %0d", obs.size(), exp.size());
        end else begin
            for (int k = 0; k < exp.size(); k++) begin
                checks++;
                if (obs[k].i !== exp[k].i || obs[k].q !== exp[k].q || obs[k].last !== exp[k].last) begin
                    errors++;
                    $display("FAIL stall_sym%0d: got (%h,%h,l=%b), expected (%h,%h,l=%b)",
                             k, obs[k].i, obs[k].q, obs[k].last, exp[k].i, exp[k].q, exp[k].last);
                end
            end
        end
    endtask

    task automatic test_valid_toggle();
        logic bits[$];
        sym_t exp[$];
        do_reset();
        for (int k = 0; k < 16; k++) bits.push_back(1'($urandom));
        build_exp(bits, 0, exp);
        foreach (bits[k]) begin
            send_bit(bits[k]);
            @(posedge clk); #1;
        end
        wait_syms(exp.size());
        checks++;
        if (obs.size() != exp.size()) begin
            errors++;
            $display("FAIL toggle_count: got %0d symbols, expected %0d", obs.size(), exp.size());
        end else begin
            for (int k = 0; k < exp.size(); k++) begin
                checks++;
                if (obs[k].i !== exp[k].i || obs[k].q !== exp[k].q || obs[k].last !== exp[k].last) begin
                    errors++;
                    $display("FAIL toggle_sym%0d: got (%h,%h,l=%b), expected (%h,%h,l=%b)",
                             k, obs[k].i, obs[k].q, obs[k].last, exp[k].i, exp[k].q, exp[k].last);
                end
                if (k > 0) begin
                    checks++;
                    if (obs[k].cyc - obs[k-1].cyc != 4) begin
                        errors++;
                        $display("FAIL toggle_spacing%0d: got %0d cycles, expected 4",
                                 k, obs[k].cyc - obs[k-1].cyc);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ready_in = 1'b0;
        send_bit(1'($urandom));
        send_bit(1'($urandom));
        send_bit(1'($urandom));
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        checks++;
        if (valid_out !== 1'b0 || i_out !== 16'h0 || q_out !== 16'h0 || last_out !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: got v=%b i=%h q=%h l=%b, expected v=0 i=0000 q=0000 l=0",
                     valid_out, i_out, q_out, last_out);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        ready_in = 1'b1;
        obs.delete();
        send_bit(1'b1);
        send_bit(1'b1);
        wait_syms(1);
        checks++;
        if (obs.size() != 1) begin
            errors++;
            $display("FAIL midreset_count: got %0d symbols, expected 1", obs.size());
        end else begin
            checks++;
            if (obs[0].i !== NEG || obs[0].q !== NEG || obs[0].last !== 1'b0) begin
                errors++;
                $display("FAIL midreset_sym: got (%h,%h,l=%b), expected (a57e,a57e,l=0)",
                         obs[0].i, obs[0].q, obs[0].last);
            end
        end
    endtask

    initial begin
        test_reset();
        test_byte_4b();
        test_full_blocks();
        test_backpressure();
        test_valid_toggle();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
